// File: rtl/pe_mac_stage.sv
// pe_mac_stage: row-level multiply-accumulate stage of a processing element.
// Runs one convolution row. It drives the address generator through pipe_en
// and if_clear, multiplies ifmap and filter taps in a two-stage pipeline, and
// accumulates each window into psum_out. psum_out has a valid/ready handshake.
// Optional feature: define PE_MAC_SATURATE_EN to clamp accumulation instead of
// wrapping modulo 2^PSUM_WIDTH.
module pe_mac_stage #(
   parameter int DATA_WIDTH = 8,
   parameter int PSUM_WIDTH = 20
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic signed [DATA_WIDTH-1:0] if_rdata,
   input  logic signed [DATA_WIDTH-1:0] filter_rdata,
   input  logic                         offset_co,
   input  logic                         if_co,
   output logic                         pipe_en,
   output logic                         if_clear,
   output logic signed [PSUM_WIDTH-1:0] psum_out,
   output logic                         psum_valid,
   input  logic                         psum_ready,
   output logic                         busy,
   output logic                         done
);

   localparam int PW2 = 2 * DATA_WIDTH;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CLEAR = 2'd1;
   localparam logic [1:0] RUN   = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   logic [1:0]                  state_q, state_d;
   logic signed [DATA_WIDTH-1:0] s1_if_q, s1_flt_q;
   logic                        s1_last_q, s1_vld_q;
   logic signed [PW2-1:0]       s2_prod_q;
   logic                        s2_last_q, s2_vld_q;
   logic signed [PSUM_WIDTH-1:0] acc_q, acc_d, psum_q;
   logic                        first_q, psum_vld_q;
   logic                        stall, drained, load_res;

   // A result that is not taken yet freezes the whole pipeline.
   assign stall    = psum_vld_q & ~psum_ready;
   assign pipe_en  = (state_q == RUN) & ~stall;
   assign if_clear = (state_q == CLEAR);
   assign busy     = (state_q != IDLE);
   assign drained  = ~s1_vld_q & ~s2_vld_q & ~psum_vld_q;
   assign done     = (state_q == DRAIN) & drained;
   assign load_res = s2_vld_q & s2_last_q & ~stall;

   assign psum_out   = psum_q;
   assign psum_valid = psum_vld_q;

   // Row sequencing: the row ends on the last tap of the last window, then the pipeline empties.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CLEAR;
         CLEAR:   state_d = RUN;
         RUN:     if (pipe_en & offset_co & if_co) state_d = DRAIN;
         DRAIN:   if (drained) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Accumulator next value. The first tap of a window starts from zero.
   always_comb begin
      logic signed [PSUM_WIDTH-1:0] base;
      logic signed [PSUM_WIDTH-1:0] prod_ext;
`ifdef PE_MAC_SATURATE_EN
      logic signed [PSUM_WIDTH:0]   sum_w;
`endif
      base     = first_q ? '0 : acc_q;
      prod_ext = {{(PSUM_WIDTH-PW2){s2_prod_q[PW2-1]}}, s2_prod_q};
`ifdef PE_MAC_SATURATE_EN
      // Add with one guard bit. Clamp when the top two bits disagree.
      sum_w = {base[PSUM_WIDTH-1], base} + {prod_ext[PSUM_WIDTH-1], prod_ext};
      if (sum_w[PSUM_WIDTH] != sum_w[PSUM_WIDTH-1])
         acc_d = sum_w[PSUM_WIDTH] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}}
                                   : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
      else
         acc_d = sum_w[PSUM_WIDTH-1:0];
`else
      acc_d = base + prod_ext;
`endif
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Operand capture, product and accumulate stages. All of them hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_if_q   <= '0;
         s1_flt_q  <= '0;
         s1_last_q <= 1'b0;
         s1_vld_q  <= 1'b0;
         s2_prod_q <= '0;
         s2_last_q <= 1'b0;
         s2_vld_q  <= 1'b0;
         acc_q     <= '0;
         first_q   <= 1'b1;
      end else if (!stall) begin
         s1_if_q   <= if_rdata;
         s1_flt_q  <= filter_rdata;
         s1_last_q <= offset_co;
         s1_vld_q  <= pipe_en;
         s2_prod_q <= s1_if_q * s1_flt_q;
         s2_last_q <= s1_last_q;
         s2_vld_q  <= s1_vld_q;
         if (s2_vld_q) begin
            acc_q   <= acc_d;
            first_q <= s2_last_q;
         end
      end
   end

   // Result register. A new result has priority over the consumer draining the old one.
   always_ff @(posedge clk) begin
      if (rst) begin
         psum_q     <= '0;
         psum_vld_q <= 1'b0;
      end else if (load_res) begin
         psum_q     <= acc_d;
         psum_vld_q <= 1'b1;
      end else if (psum_ready) begin
         psum_vld_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pe_mac_stage.sv
// Directed testbench for pe_mac_stage. It runs a default 20-bit instance and a
// 16-bit instance in lockstep on the same stimulus.
module tb_pe_mac_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, psum_ready, offset_co, if_co;
   logic signed [7:0]  if_rdata, filter_rdata;
   logic pipe_en0, if_clear0, psum_valid0, busy0, done0;
   logic pipe_en1, if_clear1, psum_valid1, busy1, done1;
   logic signed [19:0] psum0;
   logic signed [15:0] psum1;

   pe_mac_stage #(.DATA_WIDTH(8), .PSUM_WIDTH(20)) dut0 (
      .clk(clk), .rst(rst), .start(start), .if_rdata(if_rdata), .filter_rdata(filter_rdata),
      .offset_co(offset_co), .if_co(if_co), .pipe_en(pipe_en0), .if_clear(if_clear0),
      .psum_out(psum0), .psum_valid(psum_valid0), .psum_ready(psum_ready),
      .busy(busy0), .done(done0));

   pe_mac_stage #(.DATA_WIDTH(8), .PSUM_WIDTH(16)) dut1 (
      .clk(clk), .rst(rst), .start(start), .if_rdata(if_rdata), .filter_rdata(filter_rdata),
      .offset_co(offset_co), .if_co(if_co), .pipe_en(pipe_en1), .if_clear(if_clear1),
      .psum_out(psum1), .psum_valid(psum_valid1), .psum_ready(psum_ready),
      .busy(busy1), .done(done1));

   // Address generator model with asynchronous spad reads.
   int cur_fs = 1, cur_nw = 1;
   int w = 0, k = 0;
   logic signed [7:0] cur_f [4];
   logic signed [7:0] cur_i [8];
   assign if_rdata     = cur_i[(w + k) & 7];
   assign filter_rdata = cur_f[k & 3];
   assign offset_co    = (k == cur_fs - 1);
   assign if_co        = (w == cur_nw - 1);

   always @(posedge clk) begin
      if (if_clear0) begin
         w <= 0; k <= 0;
      end else if (pipe_en0) begin
         if (k == cur_fs - 1) begin k <= 0; w <= w + 1; end
         else k <= k + 1;
      end
   end

   // Monitor: records accepted psums, done and clear pulses, and lockstep divergence.
   int q0[$], q1[$];
   int done_cnt = 0, clr_cnt = 0, lock_err = 0;
   always @(negedge clk) begin
      if (psum_valid0 && psum_ready) q0.push_back(int'(psum0));
      if (psum_valid1 && psum_ready) q1.push_back(int'(psum1));
      if (done0) done_cnt <= done_cnt + 1;
      if (if_clear0) clr_cnt <= clr_cnt + 1;
      if ({pipe_en0, if_clear0, busy0, done0, psum_valid0} !=
          {pipe_en1, if_clear1, busy1, done1, psum_valid1}) lock_err <= lock_err + 1;
   end

   typedef struct packed {
      int fs; int nw; int nexp; int exp16;
      logic [3:0][31:0] ex;
      logic [3:0][7:0]  f;
      logic [7:0][7:0]  im;
   } vec_t;
   localparam int NV = 5;
   localparam int OVF = 2;
   vec_t tv [NV];

   int total = 0, bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   function automatic logic [7:0] b8(input int x);
      return x[7:0];
   endfunction

   task automatic setv(input int i, input int fs, input int nw, input int nexp,
                       input int e0, input int e1, input int e2, input int e3, input int e16);
      tv[i].fs = fs; tv[i].nw = nw; tv[i].nexp = nexp; tv[i].exp16 = e16;
      tv[i].ex[0] = e0; tv[i].ex[1] = e1; tv[i].ex[2] = e2; tv[i].ex[3] = e3;
   endtask

   task automatic setd(input int i, input int f0, input int f1, input int f2, input int f3,
                       input int i0, input int i1, input int i2, input int i3,
                       input int i4, input int i5, input int i6, input int i7);
      tv[i].f[0] = b8(f0); tv[i].f[1] = b8(f1); tv[i].f[2] = b8(f2); tv[i].f[3] = b8(f3);
      tv[i].im[0] = b8(i0); tv[i].im[1] = b8(i1); tv[i].im[2] = b8(i2); tv[i].im[3] = b8(i3);
      tv[i].im[4] = b8(i4); tv[i].im[5] = b8(i5); tv[i].im[6] = b8(i6); tv[i].im[7] = b8(i7);
   endtask

   task automatic load_vec(input int vi);
      cur_fs = tv[vi].fs; cur_nw = tv[vi].nw;
      for (int j = 0; j < 4; j++) cur_f[j] = tv[vi].f[j];
      for (int j = 0; j < 8; j++) cur_i[j] = tv[vi].im[j];
   endtask

   task automatic pulse_start;
      start = 1'b1; tick; start = 1'b0;
   endtask

   // Waits for the next done pulse, bounded. The latency check applies only when ready is held at 1.
   task automatic wait_done(input int d0, input bit chk_lat);
      int iss, vs, to;
      iss = -1; vs = -1; to = 1;
      for (int i = 0; i < 300; i++) begin
         if (iss < 0 && pipe_en0 && offset_co) iss = i;
         if (vs < 0 && psum_valid0) vs = i;
         if (done_cnt > d0) begin to = 0; break; end
         tick;
      end
      chk("row_timeout", to, 0);
      if (chk_lat) chk("latency", vs - iss, 3);
      tick; tick;
      chk("busy_after_row", int'(busy0), 0);
      chk("done_pulses", done_cnt - d0, 1);
   endtask

   task automatic check_psums(input int vi, input int n0, input int n1);
      chk("psum_count", q0.size() - n0, tv[vi].nexp);
      chk("psum_count16", q1.size() - n1, tv[vi].nexp);
      for (int j = 0; j < tv[vi].nexp; j++) begin
         if (q0.size() > n0 + j) chk($sformatf("v%0d_psum%0d", vi, j), q0[n0 + j], int'(tv[vi].ex[j]));
         if (q1.size() > n1 + j)
            chk($sformatf("v%0d_psum16_%0d", vi, j), q1[n1 + j],
                (vi == OVF) ? tv[vi].exp16 : int'(tv[vi].ex[j]));
      end
   endtask

   task automatic run_row(input int vi);
      int n0, n1, d0;
      load_vec(vi);
      n0 = q0.size(); n1 = q1.size(); d0 = done_cnt;
      pulse_start;
      wait_done(d0, 1'b1);
      check_psums(vi, n0, n1);
   endtask

   initial begin
      int n0, n1, d0, c0, to;
      int exp_ovf16;
`ifdef PE_MAC_SATURATE_EN
      exp_ovf16 = 32767;
`else
      exp_ovf16 = -17149;
`endif
      //   idx fs nw n  expected psums           16-bit result
      setv(0, 3, 3, 3, 14, 20, 26, 0,          0);
      setd(0, 1, 2, 3, 0,   1, 2, 3, 4, 5, 0, 0, 0);
      setv(1, 2, 1, 1, 128, 0, 0, 0,           128);
      setd(1, -128, -128, 0, 0,   -128, 127, 0, 0, 0, 0, 0, 0);
      setv(2, 3, 1, 1, 48387, 0, 0, 0,         exp_ovf16);
      setd(2, 127, 127, 127, 0,   127, 127, 127, 0, 0, 0, 0, 0);
      setv(3, 1, 2, 2, 15, -20, 0, 0,          0);
      setd(3, 5, 0, 0, 0,   3, -4, 0, 0, 0, 0, 0, 0);
      setv(4, 4, 1, 1, 100, 0, 0, 0,           0);
      setd(4, -1, 2, -3, 4,   10, 20, 30, 40, 0, 0, 0, 0);
      load_vec(0);

      rst = 1'b1; start = 1'b0; psum_ready = 1'b1;
      tick; tick;
      chk("rst_busy", int'(busy0), 0);
      chk("rst_psum_valid", int'(psum_valid0), 0);
      chk("rst_psum_out", int'(psum0), 0);
      chk("rst_pipe_en", int'(pipe_en0), 0);
      chk("rst_if_clear", int'(if_clear0), 0);
      chk("rst_done", int'(done0), 0);
      rst = 1'b0;
      tick;

      for (int vi = 0; vi < NV; vi++) run_row(vi);

      // Backpressure: the first psum is held for 5 cycles.
      load_vec(0);
      n0 = q0.size(); n1 = q1.size(); d0 = done_cnt;
      psum_ready = 1'b0;
      pulse_start;
      to = 1;
      for (int i = 0; i < 100; i++) begin
         if (psum_valid0) begin to = 0; break; end
         tick;
      end
      chk("bp_first_timeout", to, 0);
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("bp_pipe_en", int'(pipe_en0), 0);
         chk("bp_psum_held", int'(psum0), 14);
         chk("bp_valid_held", int'(psum_valid0), 1);
      end
      psum_ready = 1'b1;
      wait_done(d0, 1'b0);
      check_psums(0, n0, n1);

      // Reset during the second window.
      load_vec(0);
      n0 = q0.size();
      pulse_start;
      to = 1;
      for (int i = 0; i < 100; i++) begin
         if (w == 1 && k == 1) begin to = 0; break; end
         tick;
      end
      chk("mid_reset_reach", to, 0);
      rst = 1'b1; tick; rst = 1'b0;
      chk("mid_rst_psum_valid", int'(psum_valid0), 0);
      chk("mid_rst_busy", int'(busy0), 0);
      for (int i = 0; i < 6; i++) tick;
      chk("mid_rst_no_partial", q0.size() - n0, 0);
      chk("mid_rst_stay_idle", int'(busy0), 0);
      run_row(0);

      // A start pulse while in RUN must not trigger another clear.
      load_vec(0);
      n0 = q0.size(); n1 = q1.size(); d0 = done_cnt; c0 = clr_cnt;
      pulse_start;
      to = 1;
      for (int i = 0; i < 20; i++) begin
         if (pipe_en0) begin to = 0; break; end
         tick;
      end
      chk("run_reach", to, 0);
      pulse_start;
      wait_done(d0, 1'b1);
      chk("single_clear", clr_cnt - c0, 1);
      check_psums(0, n0, n1);

      chk("lockstep", lock_err, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
